parallel_to_serial: RTL and testbench
=====================================

# parallel_to_serial

Master-side bridge that accepts one parallel bus request at a time and serialises it into a 27-bit request frame on `sdata_o`/`sclk_o`/`svalid_o`. It then deserialises the 12-bit response frame returned on `sdata_i`/`sclk_resp_i`/`svalid_resp_i` and completes the parallel handshake with read data and error status. It sits directly upstream of `serial_to_parallel`: its request outputs drive that block's serial inputs, and that block's response outputs drive this block's serial inputs.

## Interface
- `SCLK_HALF_DIV`, default 2: `clk_i` cycles per `sclk_o` half-period (≥1).
- `RESP_TIMEOUT`, default 1024: `clk_i` cycles allowed between the end of the request frame and the response start bit.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  request valid; held high until `ready_o`.
- `addr_i`  in  ADDR_WIDTH(14)  request address.
- `wdata_i`  in  DATA_WIDTH(8)  write data.
- `we_i`  in  1  1 = write, 0 = read.
- `split_i`  in  1  with `we_i`=1, selects CMD_SPLIT_START; ignored for reads.
- `ready_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  8  response data; valid only while `ready_o`=1.
- `err_o`  out  1  error flag; valid only while `ready_o`=1.
- `sdata_o`  out  1  request serial data, MSB first.
- `sclk_o`  out  1  request serial clock, free-running after reset.
- `svalid_o`  out  1  request frame envelope.
- `sready_i`  in  1  downstream can accept a frame.
- `sdata_i`  in  1  response serial data.
- `sclk_resp_i`  in  1  response serial clock.
- `svalid_resp_i`  in  1  response frame envelope.

## Operation
- Request frame, MSB first: `{start=1, cmd[1:0], addr[13:0], data[7:0], parity, stop=1}`, 27 bits.
- Command encoding: CMD_READ=2'b00, CMD_WRITE=2'b01, CMD_SPLIT_START=2'b10.
- Parity is even parity, computed as XOR over the cmd, addr and data bits. For reads, the data field is 0x00.
- Response frame, MSB first: `{start=1, status, data[7:0], parity, stop=1}`, 12 bits.
  - `status`=1 means a slave error.
  - Parity is the XOR of the status and data bits.
- FSM states:
  - IDLE: waits for `valid_i`=1.
  - WAIT_RDY: waits for `sready_i`=1.
  - SHIFT: shifts out the request frame.
  - WAIT_RESP: waits for the response start bit.
  - RECV: shifts in the response frame.
  - DONE: completes the parallel handshake.
- IDLE→WAIT_RDY when `valid_i`=1. The request fields are captured into the shift register on this cycle.
- WAIT_RDY→SHIFT on the first `sclk_o` falling edge with `sready_i`=1.
- SHIFT→WAIT_RESP on the falling edge after bit 0 has been driven.
- WAIT_RESP→RECV when the synchronised `sclk_resp_i` rising edge samples `svalid_resp_i`=1 and `sdata_i`=1.
- RECV→DONE after 12 bits have been sampled.
- DONE→IDLE after one cycle.
- Error cases, all taking the FSM to DONE with `err_o`=1 and `rdata_o`=0x00:
  - WAIT_RESP timeout after RESP_TIMEOUT cycles.
  - Response parity mismatch.
  - Response stop bit = 0.
  - `svalid_resp_i` dropping mid-frame.
- Otherwise `err_o`=`status` and `rdata_o`=`data`.
- All commands, including writes, wait for a response frame.
- Reset values: `ready_o`=0, `rdata_o`=0, `err_o`=0, `sdata_o`=0, `sclk_o`=0, `svalid_o`=0; FSM in IDLE.

## Timing
- `sclk_o` toggles every SCLK_HALF_DIV cycles.
- `sdata_o` and `svalid_o` change only on the `clk_i` edge that produces a falling edge of `sclk_o`. The receiver samples on the rising edge.
- `svalid_o` rises together with the start bit. It falls, with `sdata_o`→0, on the falling edge after bit 0.
- Request serialisation takes 27 `sclk_o` periods.
- `sclk_resp_i`, `sdata_i` and `svalid_resp_i` pass through 2-flop synchronisers. A rising edge is detected when the synchronised `sclk_resp_i` goes 0→1. Sampling latency is 3 `clk_i` cycles.
- `ready_o` pulses exactly one cycle, in DONE. `valid_i` is not re-sampled until IDLE.
- If `valid_i` drops before `ready_o`, the transaction still completes (protocol violation, no abort).
- Asynchronous reset during any state, including mid-SHIFT or mid-RECV: all outputs return to their reset values immediately and the partial frame is discarded.
- The timeout counter is cleared on entry to WAIT_RESP and saturates.

## Structure
- Shared in `bus_pkg`: ADDR_WIDTH, DATA_WIDTH, `cmd_e`, `serial_frame_t`, FRAME_WIDTH(27), `calc_parity`.
- Add to `bus_pkg`: `resp_frame_t`, RESP_WIDTH(12), `calc_resp_parity`.
- One sub-module, `sclk_gen`: divider producing `sclk_o` plus single-cycle `fall_stb`/`rise_stb` strobes.

## Test plan
- WRITE, `addr_i`=0x1000, `wdata_i`=0x42, `sready_i`=1 → frame 27'h5400109 on `sdata_o`. Return response status=0, data=0x00 → `ready_o` pulse, `err_o`=0.
- READ, `addr_i`=0x1800 → cmd 00, data field 0x00, correct parity. Return response data=0x55 → `rdata_o`=0x55 during the `ready_o` pulse, `err_o`=0.
- WRITE with `split_i`=1, `addr_i`=0x0800, `wdata_i`=0x77 → cmd field 2'b10. Loopback through `serial_to_parallel` delivers addr 0x0800, data 0x77.
- Response with flipped parity bit → `ready_o` with `err_o`=1, `rdata_o`=0x00.
- No response frame → `ready_o` with `err_o`=1 exactly RESP_TIMEOUT cycles after WAIT_RESP entry.
- Hold `sready_i`=0 for 50 cycles, then 1 → `svalid_o` stays 0 until the first `sclk_o` fall after `sready_i` rises. Reset asserted mid-SHIFT → `svalid_o`=0 and `sclk_o`=0 immediately.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus/serial frame definitions for the parallel<->serial bridge pair.
// Frames are sent MSB first, so struct fields are declared in wire order.
package bus_pkg;

  localparam int ADDR_WIDTH  = 14;
  localparam int DATA_WIDTH  = 8;
  localparam int FRAME_WIDTH = 27;
  localparam int RESP_WIDTH  = 12;

  typedef enum logic [1:0] {
    CMD_READ        = 2'b00,
    CMD_WRITE       = 2'b01,
    CMD_SPLIT_START = 2'b10
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_SHIFT,
    S_WAIT_RESP,
    S_RECV,
    S_DONE
  } p2s_state_e;

  typedef struct packed {
    logic                  start;
    cmd_e                  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  parity;
    logic                  stop;
  } serial_frame_t;

  typedef struct packed {
    logic                  start;
    logic                  status;
    logic [DATA_WIDTH-1:0] data;
    logic                  parity;
    logic                  stop;
  } resp_frame_t;

  function automatic logic calc_parity(cmd_e cmd, logic [ADDR_WIDTH-1:0] addr,
                                       logic [DATA_WIDTH-1:0] data);
    return ^{cmd, addr, data};
  endfunction

  function automatic logic calc_resp_parity(logic status, logic [DATA_WIDTH-1:0] data);
    return ^{status, data};
  endfunction

endpackage

// File: rtl/parallel_to_serial_sclk_gen.sv
// Free-running serial clock divider; strobes are high in the cycle whose
// closing clk_i edge produces the corresponding sclk_o transition.
module sclk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sclk_o,
  output logic fall_stb_o,
  output logic rise_stb_o
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          wrap;

  assign wrap = (cnt_q == CW'(HALF_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign sclk_o     = sclk_q;
  assign fall_stb_o = wrap & sclk_q;
  assign rise_stb_o = wrap & ~sclk_q;

endmodule

// File: rtl/parallel_to_serial.sv
// Master bridge: one parallel request -> 27-bit serial request frame, then
// waits for and decodes the 12-bit response frame into rdata_o/err_o.
module parallel_to_serial
  import bus_pkg::*;
#(
  parameter int SCLK_HALF_DIV = 2,
  parameter int RESP_TIMEOUT  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  input  logic                  split_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  sdata_o,
  output logic                  sclk_o,
  output logic                  svalid_o,
  input  logic                  sready_i,
  input  logic                  sdata_i,
  input  logic                  sclk_resp_i,
  input  logic                  svalid_resp_i
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam int BW = $clog2(FRAME_WIDTH);
  localparam int RW = $clog2(RESP_WIDTH);

  logic fall_stb;
  logic unused_rise_stb;

  sclk_gen #(.HALF_DIV(SCLK_HALF_DIV)) u_sclk_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .sclk_o     (sclk_o),
    .fall_stb_o (fall_stb),
    .rise_stb_o (unused_rise_stb)
  );

  // All three response lines share the same sync depth so data stays aligned to its clock edge.
  logic [1:0] rclk_sync_q, rdat_sync_q, rvld_sync_q;
  logic       rclk_prev_q;
  logic       resp_rise, rdat, rvld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rclk_sync_q <= '0;
      rdat_sync_q <= '0;
      rvld_sync_q <= '0;
      rclk_prev_q <= 1'b0;
    end else begin
      rclk_sync_q <= {rclk_sync_q[0], sclk_resp_i};
      rdat_sync_q <= {rdat_sync_q[0], sdata_i};
      rvld_sync_q <= {rvld_sync_q[0], svalid_resp_i};
      rclk_prev_q <= rclk_sync_q[1];
    end
  end

  assign resp_rise = rclk_sync_q[1] & ~rclk_prev_q;
  assign rdat      = rdat_sync_q[1];
  assign rvld      = rvld_sync_q[1];

  p2s_state_e             state_q;
  logic [FRAME_WIDTH-1:0] shift_q;
  logic [BW-1:0]          bcnt_q;
  logic [TW-1:0]          tmo_q;
  logic [RESP_WIDTH-2:0]  rsh_q;
  logic [RW-1:0]          rcnt_q;

  cmd_e                   req_cmd;
  logic [DATA_WIDTH-1:0]  req_data;
  serial_frame_t          req_frame;
  resp_frame_t            resp_w;
  logic                   resp_ok;

  always_comb begin
    req_cmd = CMD_READ;
    if (we_i) req_cmd = split_i ? CMD_SPLIT_START : CMD_WRITE;
    req_data  = we_i ? wdata_i : '0;
    req_frame = '{start:  1'b1,
                  cmd:    req_cmd,
                  addr:   addr_i,
                  data:   req_data,
                  parity: calc_parity(req_cmd, addr_i, req_data),
                  stop:   1'b1};
    resp_w  = {rsh_q, rdat};
    resp_ok = resp_w.start & resp_w.stop &
              (resp_w.parity == calc_resp_parity(resp_w.status, resp_w.data));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bcnt_q   <= '0;
      tmo_q    <= '0;
      rsh_q    <= '0;
      rcnt_q   <= '0;
      ready_o  <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      sdata_o  <= 1'b0;
      svalid_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            shift_q <= req_frame;
            state_q <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (fall_stb && sready_i) begin
            sdata_o  <= shift_q[FRAME_WIDTH-1];
            svalid_o <= 1'b1;
            shift_q  <= {shift_q[FRAME_WIDTH-2:0], 1'b0};
            bcnt_q   <= BW'(FRAME_WIDTH - 1);
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // bcnt_q counts bits still to drive after the one currently on the wire.
          if (fall_stb) begin
            if (bcnt_q == '0) begin
              sdata_o  <= 1'b0;
              svalid_o <= 1'b0;
              tmo_q    <= '0;
              state_q  <= S_WAIT_RESP;
            end else begin
              sdata_o <= shift_q[FRAME_WIDTH-1];
              shift_q <= {shift_q[FRAME_WIDTH-2:0], 1'b0};
              bcnt_q  <= bcnt_q - 1'b1;
            end
          end
        end
        S_WAIT_RESP: begin
          if (resp_rise && rvld && rdat) begin
            rsh_q   <= {{(RESP_WIDTH-2){1'b0}}, 1'b1};
            rcnt_q  <= RW'(1);
            state_q <= S_RECV;
          end else if (tmo_q == TW'(RESP_TIMEOUT - 1)) begin
            ready_o <= 1'b1;
            err_o   <= 1'b1;
            rdata_o <= '0;
            state_q <= S_DONE;
          end else if (tmo_q != '1) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RECV: begin
          if (!rvld) begin
            ready_o <= 1'b1;
            err_o   <= 1'b1;
            rdata_o <= '0;
            state_q <= S_DONE;
          end else if (resp_rise) begin
            if (rcnt_q == RW'(RESP_WIDTH - 1)) begin
              ready_o <= 1'b1;
              err_o   <= resp_ok ? resp_w.status : 1'b1;
              rdata_o <= resp_ok ? resp_w.data : '0;
              state_q <= S_DONE;
            end else begin
              rsh_q  <= {rsh_q[RESP_WIDTH-3:0], rdat};
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          ready_o <= 1'b0;
          err_o   <= 1'b0;
          rdata_o <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench: stimulus queues expected request frames and completions,
// independent monitors decode sdata_o and the parallel handshake and compare.
module tb_parallel_to_serial;

  localparam int HALF = 2;
  localparam int TMO  = 200;

  localparam int K_OK = 0, K_BADPAR = 1, K_BADSTOP = 2, K_DROP = 3, K_NONE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_i = 1'b0, we_i = 1'b0, split_i = 1'b0;
  logic [13:0] addr_i = '0;
  logic [7:0]  wdata_i = '0;
  logic        ready_o, err_o, sdata_o, sclk_o, svalid_o;
  logic [7:0]  rdata_o;
  logic        sready_i = 1'b1;
  logic        sdata_r = 1'b0, sclk_r = 1'b0, svalid_r = 1'b0;

  always #5 clk = ~clk;

  parallel_to_serial #(.SCLK_HALF_DIV(HALF), .RESP_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .we_i(we_i), .split_i(split_i), .ready_o(ready_o),
    .rdata_o(rdata_o), .err_o(err_o), .sdata_o(sdata_o), .sclk_o(sclk_o),
    .svalid_o(svalid_o), .sready_i(sready_i), .sdata_i(sdata_r),
    .sclk_resp_i(sclk_r), .svalid_resp_i(svalid_r)
  );

  typedef struct { int kind; logic status; logic [7:0] data; } plan_t;
  typedef struct { logic err; logic [7:0] rdata; bit tmo; } exp_t;

  logic [26:0] req_q[$];
  plan_t       plan_q[$];
  exp_t        rsp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, sv_fall_cyc = 0, frames_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference request frame from the wire format: start, cmd, addr, data, even parity, stop.
  function automatic logic [26:0] model_frame(logic we, logic split, logic [13:0] addr,
                                              logic [7:0] wd);
    logic [1:0] cmd;
    logic [7:0] d;
    logic       p;
    cmd = !we ? 2'b00 : (split ? 2'b10 : 2'b01);
    d   = we ? wd : 8'h00;
    p   = ($countones({cmd, addr, d}) % 2) == 1;
    return {1'b1, cmd, addr, d, p, 1'b1};
  endfunction

  // Request-side monitor: decodes the serial frame and checks edge alignment.
  initial begin
    logic        prev_sclk = 0, prev_sv = 0, prev_sd = 0, prev_rst = 0;
    int          nb = 0;
    logic [26:0] sh = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) nb = 0;
      if (rst_n && prev_rst) begin
        if (svalid_o !== prev_sv || sdata_o !== prev_sd)
          check("edge_align", {30'd0, prev_sclk, sclk_o}, 32'd2);
        if (prev_sv && !svalid_o) begin
          sv_fall_cyc = cyc;
          check("sdata_idle", sdata_o, 0);
        end
        if (!prev_sclk && sclk_o && svalid_o) begin
          sh = {sh[25:0], sdata_o};
          nb++;
          if (nb == 27) begin
            if (req_q.size() == 0) fail_now("req_unexpected");
            else check("req_frame", sh, req_q.pop_front());
            nb = 0;
            frames_seen++;
          end
        end
      end
      prev_sclk = sclk_o;
      prev_sv   = svalid_o;
      prev_sd   = sdata_o;
      prev_rst  = rst_n;
    end
  end

  task automatic drive_resp(plan_t p);
    logic [11:0] f;
    if (p.kind == K_NONE) return;
    f = {1'b1, p.status, p.data, ($countones({p.status, p.data}) % 2) == 1, 1'b1};
    if (p.kind == K_BADPAR)  f[1] = ~f[1];
    if (p.kind == K_BADSTOP) f[0] = 1'b0;
    #20;
    for (int i = 11; i >= 0; i--) begin
      svalid_r = !(p.kind == K_DROP && i < 6);
      sdata_r  = f[i];
      #30 sclk_r = 1'b1;
      #30 sclk_r = 1'b0;
    end
    svalid_r = 1'b0;
    sdata_r  = 1'b0;
  endtask

  // Responder: answers each completed request frame with the next queued plan.
  initial begin
    int served = 0;
    forever begin
      wait (frames_seen > served);
      served++;
      if (plan_q.size() > 0) drive_resp(plan_q.pop_front());
    end
  end

  // Completion monitor.
  initial begin
    logic prev_rdy = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_rdy) check("ready_pulse", ready_o, 0);
      if (ready_o && !prev_rdy) begin
        if (rsp_q.size() == 0) fail_now("rsp_unexpected");
        else begin
          e = rsp_q.pop_front();
          check("err", err_o, e.err);
          check("rdata", rdata_o, e.rdata);
          if (e.tmo) check("timeout_cycles", cyc - sv_fall_cyc, TMO);
        end
      end
      prev_rdy = ready_o;
    end
  end

  task automatic push_exp(logic [26:0] frame, int kind, logic st, logic [7:0] rd);
    plan_t p;
    exp_t  e;
    req_q.push_back(frame);
    p.kind = kind; p.status = st; p.data = rd;
    plan_q.push_back(p);
    e.tmo   = (kind == K_NONE);
    e.err   = (kind == K_OK) ? st : 1'b1;
    e.rdata = (kind == K_OK) ? rd : 8'h00;
    rsp_q.push_back(e);
  endtask

  task automatic wait_ready(int budget);
    int n = 0;
    while (!ready_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) fail_now("ready_timeout");
  endtask

  task automatic drive_req(logic we, logic split, logic [13:0] addr, logic [7:0] wd);
    @(negedge clk);
    valid_i = 1'b1; we_i = we; split_i = split; addr_i = addr; wdata_i = wd;
  endtask

  task automatic run_txn(logic [26:0] frame, logic we, logic split, logic [13:0] addr,
                         logic [7:0] wd, int kind, logic st, logic [7:0] rd);
    push_exp(frame, kind, st, rd);
    drive_req(we, split, addr, wd);
    wait_ready(1000);
    valid_i = 1'b0;
  endtask

  initial begin
    logic        we, split, seen, prev_sclk;
    logic [13:0] a;
    logic [7:0]  d, rd;
    int          k, n;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_err", err_o, 0);
    check("rst_sdata", sdata_o, 0);
    check("rst_sclk", sclk_o, 0);
    check("rst_svalid", svalid_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(27'h5400109, 1, 0, 14'h1000, 8'h42, K_OK, 1'b0, 8'h00);
    run_txn(27'h4600001, 0, 0, 14'h1800, 8'hEE, K_OK, 1'b0, 8'h55);
    run_txn(27'h62001DD, 1, 1, 14'h0800, 8'h77, K_OK, 1'b0, 8'h00);
    run_txn(model_frame(1, 0, 14'h0123, 8'h3C), 1, 0, 14'h0123, 8'h3C, K_BADPAR, 1'b0, 8'h3C);
    run_txn(model_frame(0, 0, 14'h2AAA, 8'h00), 0, 0, 14'h2AAA, 8'h00, K_NONE, 1'b0, 8'h00);
    run_txn(model_frame(0, 1, 14'h3FFF, 8'h11), 0, 1, 14'h3FFF, 8'h11, K_OK, 1'b1, 8'hA5);
    run_txn(model_frame(1, 0, 14'h0001, 8'hFF), 1, 0, 14'h0001, 8'hFF, K_BADSTOP, 1'b0, 8'h12);
    run_txn(model_frame(1, 1, 14'h1234, 8'h80), 1, 1, 14'h1234, 8'h80, K_DROP, 1'b0, 8'h99);

    // Downstream not ready: no frame may start until sready_i rises.
    sready_i = 1'b0;
    push_exp(model_frame(1, 0, 14'h0F0F, 8'h5A), K_OK, 1'b0, 8'hC3);
    drive_req(1, 0, 14'h0F0F, 8'h5A);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (svalid_o) seen = 1'b1;
    end
    check("sready_hold_svalid", seen, 0);
    sready_i  = 1'b1;
    prev_sclk = sclk_o;
    n = 0;
    while (!svalid_o && n < 40) begin
      prev_sclk = sclk_o;
      @(negedge clk);
      n++;
    end
    if (!svalid_o) fail_now("sready_start_timeout");
    else check("sready_start_on_fall", {prev_sclk, sclk_o}, 2'b10);
    wait_ready(1000);
    valid_i = 1'b0;

    for (int t = 0; t < 30; t++) begin
      we = 1'($urandom); split = 1'($urandom);
      a = 14'($urandom); d = 8'($urandom); rd = 8'($urandom);
      k = $urandom_range(0, 7);
      k = (k < 4) ? K_OK : (k == 4) ? K_BADPAR : (k == 5) ? K_BADSTOP : (k == 6) ? K_DROP : K_NONE;
      run_txn(model_frame(we, split, a, d), we, split, a, d, k, 1'($urandom), rd);
    end

    // Asynchronous reset in the middle of a request frame.
    drive_req(1, 0, 14'h2222, 8'h44);
    n = 0;
    while (!svalid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!svalid_o) fail_now("shift_start_timeout");
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midshift_rst_svalid", svalid_o, 0);
    check("midshift_rst_sclk", sclk_o, 0);
    check("midshift_rst_sdata", sdata_o, 0);
    check("midshift_rst_ready", ready_o, 0);
    valid_i = 1'b0;
    req_q.delete();
    plan_q.delete();
    rsp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(model_frame(0, 0, 14'h0ABC, 8'h00), 0, 0, 14'h0ABC, 8'h00, K_OK, 1'b0, 8'h6E);
    repeat (100) @(negedge clk);
    check("req_queue_drained", req_q.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
